instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Program sequencer that drives the autoencoder datapath: replaces the free-running instruction counter.
//  Generates the instruction-memory address (pc), qualifies each fetched 16-bit instruction with instr_valid,
//  stops on an END opcode and re-runs the program body for a programmable number of epochs.
//  Downstream CU/sel_mem consume instruction_out only when instr_valid=1.
// PARAMETERS
//  ADDR_W      16     width of pc / instruction-memory address
//  EPOCH_W     8      width of epoch count
//  START_ADDR  0      first address fetched after start
//  END_OPCODE  4'hF   opcode (instr[15:12]) marking end of program body; never issued
// PORTS
//  clock            in   1        single clock, rising edge
//  reset            in   1        asynchronous, active-high
//  start            in   1        begin run; sampled only in IDLE
//  stop             in   1        synchronous abort; returns to IDLE, no done pulse
//  epochs           in   EPOCH_W  number of passes; sampled at start; 0 treated as 1
//  loop_addr        in   ADDR_W   restart address for epochs 2..N; sampled at start
//  instr_in         in   16       instruction-memory data (synchronous read, 1-cycle latency from pc)
//  pc               out  ADDR_W   instruction-memory address
//  instruction_out  out  16       registered instruction to CU/datapath
//  instr_valid      out  1        instruction_out is a real instruction this cycle
//  busy             out  1        state==RUN
//  done             out  1        one-cycle pulse on normal completion
//  epoch_cnt        out  EPOCH_W  completed epochs in the current run
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, instruction_out=16'h0000, instr_valid=0, busy=0, done=0, epoch_cnt=0, fetch_vld=0.
//  States: IDLE, RUN, DONE.
//  IDLE: start=1 -> pc<=START_ADDR, epoch_cnt<=0, latch epochs/loop_addr, fetch_vld<=0, -> RUN.
//  RUN, every edge: pc<=pc+1 (wraps 2^ADDR_W-1 -> 0, no flag). fetch_vld<=1.
//    - fetch_vld=1 and instr_in[15:12]!=END_OPCODE: instruction_out<=instr_in, instr_valid<=1.
//    - fetch_vld=1 and END opcode: instr_valid<=0. If epoch_cnt+1 < epochs_eff:
//      pc<=loop_addr, epoch_cnt<=epoch_cnt+1, fetch_vld<=0 (squash stale word). Else epoch_cnt<=epoch_cnt+1, -> DONE.
//    - fetch_vld=0: instr_valid<=0 (word is stale/unfetched).
//  DONE: done=1 for exactly one cycle, instr_valid=0, busy=0; next edge -> IDLE. epoch_cnt holds until next start.
//  Latency: start sampled at edge E0 -> first instr_valid=1 after E2. Redirect costs 2 bubble cycles
//    (END slot + squashed slot).
//  instruction_out holds its last value when instr_valid=0; consumers must gate on instr_valid.
//  start while RUN/DONE: ignored. stop has priority over all RUN actions: -> IDLE, instr_valid<=0, pc holds.
//  stop and start same cycle in IDLE: stop wins, stay IDLE.
//  Async reset mid-run: all outputs immediately to reset values; no done pulse.
//  epoch_cnt saturates by construction (bounded by epochs); pc arithmetic is modulo 2^ADDR_W.
// TESTING
//  1 Reset: assert reset mid-RUN -> pc=0, instr_valid=0, busy=0, done=0 same cycle (async).
//  2 Single pass: mem={A,B,C,F000}, epochs=1, start -> instr_valid high 3 cycles issuing A,B,C from E2;
//    done pulse 1 cycle; epoch_cnt=1; F000 never issued.
//  3 Loop: same mem, epochs=2, loop_addr=1 -> issue sequence A,B,C,B,C; exactly 2 bubbles between C and B;
//    epoch_cnt=2 at done.
//  4 epochs=0 -> behaves as epochs=1 (A,B,C then done).
//  5 stop asserted after B issued -> IDLE next edge, no done, no further instr_valid; new start restarts at A.
//  6 Wrap: ADDR_W=4, START_ADDR=14, mem[14]=X, mem[15]=Y, mem[0]=F000 -> X,Y issued, pc wraps to 0, done.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: run control, instruction-memory port and
// issue stream towards the CU/datapath.
interface instr_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int EPOCH_W = 8
);
    logic               start;
    logic               stop;
    logic [EPOCH_W-1:0] epochs;
    logic [ADDR_W-1:0]  loop_addr;
    logic [15:0]        instr_in;
    logic [ADDR_W-1:0]  pc;
    logic [15:0]        instruction_out;
    logic               instr_valid;
    logic               busy;
    logic               done;
    logic [EPOCH_W-1:0] epoch_cnt;

    modport master (
        input  start,
        input  stop,
        input  epochs,
        input  loop_addr,
        input  instr_in,
        output pc,
        output instruction_out,
        output instr_valid,
        output busy,
        output done,
        output epoch_cnt
    );

    modport slave (
        output start,
        output stop,
        output epochs,
        output loop_addr,
        output instr_in,
        input  pc,
        input  instruction_out,
        input  instr_valid,
        input  busy,
        input  done,
        input  epoch_cnt
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches from a 1-cycle instruction memory,
// issues until END, and re-runs the loop body for N epochs.
module instr_sequencer #(
    parameter int               ADDR_W     = 16,
    parameter int               EPOCH_W    = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [3:0]       END_OPCODE = 4'hF
) (
    input logic               clock,
    input logic               reset,
    instr_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc_q, pc_n;
    logic [15:0]        instr_q, instr_n;
    logic               valid_q, valid_n;
    logic [EPOCH_W-1:0] epoch_q, epoch_n;
    logic               fetch_vld, fetch_n;
    logic [EPOCH_W-1:0] eff_q, eff_n;
    logic [ADDR_W-1:0]  loop_q, loop_n;

    logic [EPOCH_W:0]   ep_inc;
    logic               is_end;
    logic               more;

    assign ep_inc = {1'b0, epoch_q} + {{EPOCH_W{1'b0}}, 1'b1};
    assign is_end = (bus.instr_in[15:12] == END_OPCODE);
    assign more   = (ep_inc < {1'b0, eff_q});

    // State and datapath registers; async reset clears every output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            instr_q   <= 16'h0000;
            valid_q   <= 1'b0;
            epoch_q   <= '0;
            fetch_vld <= 1'b0;
            eff_q     <= '0;
            loop_q    <= '0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            instr_q   <= instr_n;
            valid_q   <= valid_n;
            epoch_q   <= epoch_n;
            fetch_vld <= fetch_n;
            eff_q     <= eff_n;
            loop_q    <= loop_n;
        end
    end

    // Next-state: fetch/issue, END handling, epoch redirect, stop abort
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        instr_n = instr_q;
        valid_n = 1'b0;
        epoch_n = epoch_q;
        fetch_n = fetch_vld;
        eff_n   = eff_q;
        loop_n  = loop_q;
        unique case (state)
            IDLE: begin
                if (!bus.stop && bus.start) begin
                    pc_n    = START_ADDR;
                    epoch_n = '0;
                    eff_n   = (bus.epochs == '0) ? EPOCH_W'(1)
                                                 : bus.epochs;
                    loop_n  = bus.loop_addr;
                    fetch_n = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    fetch_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    pc_n    = pc_q + ADDR_W'(1);
                    fetch_n = 1'b1;
                    if (fetch_vld) begin
                        if (!is_end) begin
                            instr_n = bus.instr_in;
                            valid_n = 1'b1;
                        end else begin
                            epoch_n = ep_inc[EPOCH_W-1:0];
                            if (more) begin
                                // word fetched from pc+1 is stale
                                pc_n    = loop_q;
                                fetch_n = 1'b0;
                            end else begin
                                state_n = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                fetch_n = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.pc              = pc_q;
    assign bus.instruction_out = instr_q;
    assign bus.instr_valid     = valid_q;
    assign bus.busy            = (state == RUN);
    assign bus.done            = (state == DONE);
    assign bus.epoch_cnt       = epoch_q;

endmodule
